// File: rtl/fir_out_requant_if.sv
// rtl/fir_out_requant_if.sv - valid/ready output stream carrying requantised samples
interface fir_out_requant_if #(
    parameter int OUT_W = 18
) ();
    logic signed [OUT_W-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - FIR output round/saturate to OUT_W, FIFO to a valid/ready stream, sat/ovf stats
module fir_out_requant #(
    parameter int IN_W    = 54,
    parameter int OUT_W   = 18,
    parameter int SHIFT   = 17,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic signed [IN_W-1:0] din,
    input  logic                   clr,
    fir_out_requant_if.master      m_axis,
    output logic [15:0]            sat_cnt,
    output logic                   ovf
);
    localparam int AW = $clog2(DEPTH);

    localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [LATENCY-1:0]       r_vld_sr;
    logic                     r_q_vld;
    logic signed [OUT_W-1:0]  r_q_data;
    logic [15:0]              r_sat_cnt;
    logic                     r_ovf;
    logic [AW:0]              r_wr_ptr;
    logic [AW:0]              r_rd_ptr;
    logic signed [OUT_W-1:0]  r_mem [DEPTH];

    logic                     w_stage0;
    logic signed [IN_W:0]     w_sum;
    logic signed [IN_W:0]     w_shr;
    logic                     w_over;
    logic                     w_under;
    logic signed [OUT_W-1:0]  w_sat_val;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_rd;
    logic                     w_wr;
    logic                     w_drop;

    // ena is recovered as a per-sample valid by mirroring the filter pipeline depth
    generate
        if (LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld_sr <= '0;
                else        r_vld_sr <= ena;
            end
        end else begin : g_latn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld_sr <= '0;
                else        r_vld_sr <= {r_vld_sr[LATENCY-2:0], ena};
            end
        end
    endgenerate

    // One extra bit keeps the +half addition from wrapping at the positive extreme
    always_comb begin
        w_stage0  = r_vld_sr[LATENCY-1];
        w_sum     = $signed({din[IN_W-1], din}) + RND;
        w_shr     = w_sum >>> SHIFT;
        w_over    = w_shr > SAT_MAX;
        w_under   = w_shr < SAT_MIN;
        w_sat_val = w_shr[OUT_W-1:0];
        if (w_over)  w_sat_val = OUT_MAX;
        if (w_under) w_sat_val = OUT_MIN;
    end

    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_rd    = !w_empty && m_axis.m_ready;
        w_wr    = r_q_vld && (!w_full || w_rd);
        w_drop  = r_q_vld && w_full && !w_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_vld  <= 1'b0;
            r_q_data <= '0;
        end else begin
            r_q_vld <= w_stage0;
            if (w_stage0) r_q_data <= w_sat_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (clr)
                r_sat_cnt <= '0;
            else if (w_stage0 && (w_over || w_under) && r_sat_cnt != 16'hFFFF)
                r_sat_cnt <= r_sat_cnt + 16'd1;
            // a drop on the clearing edge must still be reported
            if (w_drop)   r_ovf <= 1'b1;
            else if (clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_rd) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_q_data;
    end

    // Head is forced to zero while empty so reset clears m_data without clearing storage
    assign m_axis.m_valid = !w_empty;
    assign m_axis.m_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign sat_cnt        = r_sat_cnt;
    assign ovf            = r_ovf;
endmodule

// File: tb/tb_fir_out_requant.sv
// tb/tb_fir_out_requant.sv - randomized and directed bench for fir_out_requant with a queue-based reference model
module tb_fir_out_requant;
    localparam int IN_W    = 54;
    localparam int OUT_W   = 18;
    localparam int SHIFT   = 17;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ena;
    logic                   clr;
    logic signed [IN_W-1:0] din;
    logic [15:0]            sat_cnt;
    logic                   ovf;

    fir_out_requant_if #(.OUT_W(OUT_W)) s_if ();

    fir_out_requant #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .LATENCY(LATENCY), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .clr(clr),
        .m_axis(s_if), .sat_cnt(sat_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Filter emulation: the value given with ena appears on din LATENCY-1 edges later
    longint samp;
    longint fir_dly [LATENCY];
    always @(posedge clk) begin
        for (int i = LATENCY-1; i > 0; i--) fir_dly[i] <= fir_dly[i-1];
        fir_dly[0] <= samp;
    end
    assign din = fir_dly[LATENCY-1][IN_W-1:0];

    function automatic longint requant(input longint x);
        longint s, q, lim;
        s   = x + (64'sd1 <<< (SHIFT-1));
        q   = s / (64'sd1 <<< SHIFT);
        if ((s % (64'sd1 <<< SHIFT)) != 0 && s < 0) q = q - 1;
        lim = 64'sd1 <<< (OUT_W-1);
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
        return q;
    endfunction

    function automatic bit saturates(input longint x);
        longint s, q, lim;
        s   = x + (64'sd1 <<< (SHIFT-1));
        q   = s / (64'sd1 <<< SHIFT);
        if ((s % (64'sd1 <<< SHIFT)) != 0 && s < 0) q = q - 1;
        lim = 64'sd1 <<< (OUT_W-1);
        return (q > lim - 1) || (q < -lim);
    endfunction

    // Reference model: each accepted ena produces a sat event at +LATENCY and a FIFO write at +LATENCY+1
    typedef struct { longint due; longint val; } wr_t;
    wr_t    wq [$];
    longint satq [$];
    longint mfifo [$];
    int     m_sat;
    bit     m_ovf;
    longint edge_n = 0;
    wr_t    w_item;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq.delete(); satq.delete(); mfifo.delete();
            m_sat = 0;
            m_ovf = 0;
        end else begin
            edge_n++;
            if (mfifo.size() > 0 && s_if.m_ready) void'(mfifo.pop_front());
            if (clr) begin
                m_sat = 0;
                m_ovf = 0;
            end
            while (satq.size() > 0 && satq[0] == edge_n) begin
                void'(satq.pop_front());
                if (!clr && m_sat < 65535) m_sat++;
            end
            while (wq.size() > 0 && wq[0].due == edge_n) begin
                w_item = wq.pop_front();
                if (mfifo.size() < DEPTH) mfifo.push_back(w_item.val);
                else m_ovf = 1;
            end
            if (ena) begin
                w_item.due = edge_n + LATENCY + 1;
                w_item.val = requant(samp);
                wq.push_back(w_item);
                if (saturates(samp)) satq.push_back(edge_n + LATENCY);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("m_valid", s_if.m_valid, mfifo.size() > 0);
            if (mfifo.size() > 0) check("m_data", s_if.m_data, mfifo[0]);
            check("sat_cnt", sat_cnt, m_sat);
            check("ovf", ovf, m_ovf);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input longint v);
        ena  = 1'b1;
        samp = v;
        @(negedge clk);
        ena  = 1'b0;
        samp = longint'($urandom);
    endtask

    task automatic pop_check(input string name, input longint exp);
        int t = 0;
        while (!s_if.m_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "_valid"}, s_if.m_valid, 1);
        check(name, s_if.m_data, exp);
        s_if.m_ready = 1'b1;
        @(negedge clk);
        s_if.m_ready = 1'b0;
    endtask

    function automatic longint rand_sample();
        int sel;
        sel = $urandom_range(0, 2);
        if (sel == 0)
            return longint'($urandom_range(0, 4000000)) - 2000000;
        if (sel == 1)
            return (longint'($urandom_range(0, 262146)) - 131073) * 131072
                   + ($urandom_range(0, 1) ? 65536 : -65536) + longint'($urandom_range(0, 2)) - 1;
        return longint'($signed({$urandom, $urandom})) >>> 12;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < LATENCY; i++) fir_dly[i] = 0;
        rst_n = 1'b0; ena = 1'b0; clr = 1'b0; samp = 0; s_if.m_ready = 1'b0;
        cyc(3);
        check("rst_m_valid", s_if.m_valid, 0);
        check("rst_m_data", s_if.m_data, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        cyc(2);

        // impulse: m_valid must rise exactly LATENCY+1 edges after the ena edge
        ena = 1'b1; samp = 1000 * 131072;
        for (int j = 0; j <= LATENCY + 1; j++) begin
            @(negedge clk);
            if (j == 0) begin ena = 1'b0; samp = 0; end
            check("impulse_valid_edge", s_if.m_valid, (j == LATENCY + 1));
        end
        check("impulse_data", s_if.m_data, 1000);
        check("impulse_sat", sat_cnt, 0);
        pop_check("impulse_pop", 1000);

        // rounding half-up
        ena = 1'b1;
        samp = 65536;  @(negedge clk);
        samp = 65535;  @(negedge clk);
        samp = -65536; @(negedge clk);
        samp = -65537; @(negedge clk);
        ena = 1'b0;
        cyc(LATENCY + 2);
        pop_check("round_p_half", 1);
        pop_check("round_below_half", 0);
        pop_check("round_n_half", 0);
        pop_check("round_below_n_half", -1);
        check("round_empty", s_if.m_valid, 0);

        // saturation and clear
        ena = 1'b1;
        samp = 64'sd1 <<< 40;    @(negedge clk);
        samp = -(64'sd1 <<< 40); @(negedge clk);
        ena = 1'b0;
        cyc(LATENCY + 2);
        pop_check("sat_pos", 131071);
        pop_check("sat_neg", -131072);
        check("sat_cnt_two", sat_cnt, 2);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("sat_cnt_clr", sat_cnt, 0);

        // overflow: ten samples into an eight-deep FIFO
        for (int i = 1; i <= 10; i++) begin
            ena = 1'b1; samp = longint'(i) * 131072; @(negedge clk);
        end
        ena = 1'b0;
        cyc(LATENCY + 2);
        check("ovf_set", ovf, 1);
        for (int i = 1; i <= 8; i++) pop_check("ovf_pop", i);
        check("ovf_empty", s_if.m_valid, 0);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("ovf_clr", ovf, 0);

        // full with simultaneous read and write
        for (int i = 11; i <= 18; i++) begin
            ena = 1'b1; samp = longint'(i) * 131072; @(negedge clk);
        end
        ena = 1'b0;
        cyc(LATENCY + 2);
        check("full_ovf_clear", ovf, 0);
        ena = 1'b1; samp = 19 * 131072;
        for (int j = 0; j <= LATENCY + 1; j++) begin
            @(negedge clk);
            if (j == 0) ena = 1'b0;
            if (j == LATENCY) s_if.m_ready = 1'b1;
            if (j == LATENCY + 1) s_if.m_ready = 1'b0;
        end
        check("full_rw_no_drop", ovf, 0);
        for (int i = 12; i <= 19; i++) pop_check("full_rw_pop", i);
        check("full_rw_empty", s_if.m_valid, 0);

        // reset mid-stream with three queued and two in flight
        for (int i = 21; i <= 23; i++) begin
            ena = 1'b1; samp = longint'(i) * 131072; @(negedge clk);
        end
        ena = 1'b0;
        cyc(LATENCY + 2);
        send(24 * 131072);
        send(25 * 131072);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", s_if.m_valid, 0);
        check("midrst_m_data", s_if.m_data, 0);
        check("midrst_sat_cnt", sat_cnt, 0);
        check("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(LATENCY + 8);
        check("midrst_no_stale", s_if.m_valid, 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ena          = ($urandom_range(0, 9) < 7);
            samp         = rand_sample();
            s_if.m_ready = $urandom_range(0, 1);
            clr          = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        ena = 1'b0; clr = 1'b0; s_if.m_ready = 1'b1;
        cyc(LATENCY + DEPTH + 4);
        check("drain_empty", s_if.m_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output-side companion to the FIR filter top. It consumes the filter's 54-bit `dout` together with the same `ena` that drives the filter, and recovers a per-sample valid by delaying `ena` through the filter latency. Each valid result is rounded and saturated to 18-bit signed and queued in a small FIFO. The block presents the queue downstream on a valid/ready stream and keeps saturation and overflow statistics.

## Interface
Parameters:
- `IN_W`, 54, filter result width (signed).
- `OUT_W`, 18, output sample width (signed).
- `SHIFT`, 17, LSBs discarded by rounding; range 1..IN_W-OUT_W.
- `LATENCY`, 4, rising edges from the filter sampling `ena`=1 to the corresponding `dout` being valid; must be ≥1.
- `DEPTH`, 8, FIFO depth; power of two.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: same signal as the filter's `ena`; one input sample per cycle high.
- `din` input IN_W: filter `dout`, two's complement.
- `clr` input 1: synchronous clear of `sat_cnt` and `ovf`.
- `m_data` output OUT_W: FIFO head sample, signed.
- `m_valid` output 1: FIFO non-empty.
- `m_ready` input 1: downstream accepts `m_data` on this edge if `m_valid`.
- `sat_cnt` output 16: count of saturated samples; sticks at 0xFFFF.
- `ovf` output 1: sticky; a sample was dropped because the FIFO was full.

## Operation
- Valid tracking: `vld_sr` is a LATENCY-bit shift register. `ena` shifts into bit 0 each edge. Stage-0 valid = `vld_sr[LATENCY-1]`.
- Stage 1 (register): when stage-0 valid, compute `r = din + 2^(SHIFT-1)` at IN_W+1 bits, then arithmetic `>>> SHIFT`.
  - If `r > 2^(OUT_W-1)-1`, the result is 131071. If `r < -2^(OUT_W-1)`, the result is -131072. Otherwise the result is `r`.
  - The result is latched into `q_data` with `q_vld`=1. When stage-0 is not valid, `q_vld`=0.
  - Rounding is round-half-up: +0.5 goes to 1, and -0.5 goes to 0.
- Saturation counting: when stage 1 saturates, `sat_cnt` increments by 1, holding at 0xFFFF. `clr` wins over a simultaneous increment, so the count becomes 0.
- FIFO: `DEPTH` entries, pointer-based, one bit of pointer extension for full/empty.
  - Write occurs when `q_vld`. Read occurs when `m_valid && m_ready`.
  - If full and `q_vld` with no read on the same edge, the sample is dropped and `ovf`←1. `clr` clears `ovf`; a drop on the same edge as `clr` leaves `ovf`=1.
  - If full and a read and write occur on the same edge, both succeed and nothing is dropped.
  - If empty, only a write can occur. A read is impossible because `m_valid`=0.
  - `m_data` is driven from the head entry. `m_data` value is don't-care while `m_valid`=0.
- Reset (`rst_n`=0, any time, including mid-stream) does the following:
  - `vld_sr`, `q_vld`, and pointers are set to 0; the FIFO is emptied.
  - `m_valid`=0, `m_data`=0, `sat_cnt`=0, `ovf`=0.
  - In-flight samples are discarded.
  - Operation resumes on the first edge after `rst_n` rises.

## Timing
- Edge k samples `ena`=1 → `vld_sr[LATENCY-1]`=1 after edge k+LATENCY-1 → `din` captured into stage 1 at edge k+LATENCY → FIFO write at edge k+LATENCY+1.
- `m_valid`=1 after edge k+LATENCY+1, giving LATENCY+1 edges from `ena` to `m_valid`.
- Throughput is one sample per clock. `ena` held high continuously with `m_ready`=1 gives `m_valid` continuously high after the initial latency.
- `m_ready` has no combinational path to any other output except through registered pointers.
- The FIFO has no bypass, so the empty-to-valid transition always takes the write edge.

## Test plan
- Impulse: reset, then `ena`=1 and filter path driven so that `din`=131072000 (1000·2^17) at the capture edge. Required: `m_data`=1000, `m_valid` rising exactly LATENCY+1 edges after the `ena` edge, `sat_cnt`=0.
- Rounding: `din` = 65536, 65535, -65536, -65537 on consecutive valid cycles. Required: `m_data` = 1, 0, 0, -1 in order.
- Saturation: `din` = 2^40 then -2^40. Required: `m_data` = 131071 then -131072, `sat_cnt`=2. Then `clr` pulse → `sat_cnt`=0.
- Overflow: `m_ready`=0, 10 consecutive valid samples with values 1..10 (·2^17). Required: `ovf`=1 and FIFO holds 8 entries. Then `m_ready`=1 → outputs 1..8 in order, after which `m_valid`=0.
- Full with simultaneous read/write: fill to 8, then one edge with `m_ready`=1 and a new valid sample. Required: no drop, `ovf` stays 0, the new sample appears last.
- Reset mid-stream: assert `rst_n`=0 with 3 samples in the FIFO and 2 in flight. Required: all outputs are 0 immediately (asynchronous), and no stale sample appears after release.
